fpu_norm_round: RTL and testbench

- Downstream stage of the integer add/subtract ALU in the 64-bit FP adder.
- Consumes the signed-magnitude extended sum: WIDTH+1-bit magnitude, result sign, and the tentative biased exponent of the larger operand.
- Normalises iteratively, one bit per cycle, then rounds to nearest-even and packs an IEEE-754 double with exception flags.
- Valid/ready handshake on both sides; one transaction in flight.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_norm_round_if.sv | 26 ++
 rtl/fpu_round_rne.sv | 42 ++++
 rtl/fpu_norm_round.sv | 99 +++++++++
 tb/tb_fpu_norm_round.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and FSM state encoding for the FP adder normalise/round stage.
package fpu_pkg;
  localparam int WIDTH      = 64;
  localparam int EXP_W      = 11;
  localparam int FRAC_W     = 52;
  localparam int IEXP_W     = 13;
  localparam int BIAS       = 1023;
  localparam int EXP_INF    = 2047;
  localparam int CARRY_BIT  = 64;
  localparam int HIDDEN_BIT = 63;
  localparam int LSB_BIT    = 11;
  localparam int GUARD_BIT  = 10;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fpu_norm_round_if.sv
// Handshake bundle between the integer ALU, the normalise/round stage and its consumer.
interface fpu_norm_round_if;
  import fpu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH:0]       in_mant;
  logic                 in_sign;
  logic [EXP_W-1:0]     in_exp;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_result;
  logic                 out_overflow;
  logic                 out_underflow;
  logic                 out_inexact;

  modport slave (
    input  in_valid, in_mant, in_sign, in_exp, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport master (
    output in_valid, in_mant, in_sign, in_exp, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fpu_round_rne.sv
// Combinational round-to-nearest-even and IEEE-754 double packing of a normalised significand.
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [HIDDEN_BIT:0]      i_mant,
  input  logic signed [IEXP_W-1:0] i_exp,
  input  logic                     i_sign,
  output logic [63:0]              o_result,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic                     o_inexact
);
  localparam logic signed [IEXP_W-1:0] EXP_INF_S = IEXP_W'(EXP_INF);

  logic                     w_lsb, w_g, w_rs, w_up, w_inexact, w_hidden, w_ovf;
  logic [FRAC_W+1:0]        w_sig;
  logic signed [IEXP_W-1:0] w_exp_r;
  logic [FRAC_W-1:0]        w_frac;
  logic [EXP_W-1:0]         w_enc;

  assign w_lsb     = i_mant[LSB_BIT];
  assign w_g       = i_mant[GUARD_BIT];
  assign w_rs      = |i_mant[GUARD_BIT-1:0];
  assign w_up      = w_g & (w_rs | w_lsb);
  assign w_inexact = w_g | w_rs;
  assign w_sig     = {1'b0, i_mant[HIDDEN_BIT:LSB_BIT]} + {{(FRAC_W+1){1'b0}}, w_up};

  // A carry out of the significand leaves 1.000..: fraction clears, exponent bumps.
  always_comb begin
    w_exp_r  = w_sig[FRAC_W+1] ? i_exp + 13'sd1 : i_exp;
    w_frac   = w_sig[FRAC_W+1] ? '0 : w_sig[FRAC_W-1:0];
    w_hidden = w_sig[FRAC_W+1] | w_sig[FRAC_W];
    w_enc    = w_hidden ? w_exp_r[EXP_W-1:0] : '0;
    w_ovf    = (w_exp_r >= EXP_INF_S);
  end

  assign o_result    = w_ovf ? {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                             : {i_sign, w_enc, w_frac};
  assign o_overflow  = w_ovf;
  assign o_inexact   = w_ovf | w_inexact;
  assign o_underflow = ~w_ovf & (w_enc == '0) & w_inexact;
endmodule

// File: rtl/fpu_norm_round.sv
// Iterative one-bit-per-cycle normaliser feeding the RNE rounder; one transaction in flight.
module fpu_norm_round
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fpu_norm_round_if.slave  bus
);
  state_t                   r_state;
  logic [WIDTH:0]           r_mant;
  logic signed [IEXP_W-1:0] r_exp;
  logic                     r_sign;
  logic                     r_out_valid;
  logic [63:0]              r_result;
  logic                     r_ovf, r_unf, r_inx;

  logic [63:0]              w_result;
  logic                     w_ovf, w_unf, w_inx;
  logic                     w_in_ready;

  assign w_in_ready = (r_state == IDLE);

  fpu_round_rne u_round (
    .i_mant      (r_mant[HIDDEN_BIT:0]),
    .i_exp       (r_exp),
    .i_sign      (r_sign),
    .o_result    (w_result),
    .o_overflow  (w_ovf),
    .o_underflow (w_unf),
    .o_inexact   (w_inx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inx       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mant  <= bus.in_mant;
            r_exp   <= $signed({2'b00, bus.in_exp});
            r_sign  <= bus.in_sign;
            r_state <= NORM;
          end
        end
        NORM: begin
          if (r_mant == '0) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
            r_state  <= DONE;
          end else if (r_mant[CARRY_BIT]) begin
            // Fold the dropped bit into bit 0 so the sticky information survives.
            r_mant  <= {1'b0, r_mant[CARRY_BIT:2], r_mant[1] | r_mant[0]};
            r_exp   <= r_exp + 13'sd1;
            r_state <= ROUND;
          end else if (r_mant[HIDDEN_BIT] || r_exp == 13'sd1) begin
            r_state <= ROUND;
          end else begin
            r_mant <= {r_mant[HIDDEN_BIT:0], 1'b0};
            r_exp  <= r_exp - 13'sd1;
          end
        end
        ROUND: begin
          r_result <= w_result;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_inx    <= w_inx;
          r_state  <= DONE;
        end
        DONE: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_result    = r_result;
  assign bus.out_overflow  = r_ovf;
  assign bus.out_underflow = r_unf;
  assign bus.out_inexact   = r_inx;
endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed and randomised checks of fpu_norm_round against a value-level reference model.
module tb_fpu_norm_round;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fpu_norm_round_if bus ();

  fpu_norm_round u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: find the leading one, shift as far as the exponent allows, then RNE on integers.
  function automatic void ref_model(input logic [64:0] m, input int e, input logic s,
                                    output logic [63:0] res, output logic [2:0] flg,
                                    output int lat);
    int         p, sh, ee, rem, half;
    logic [64:0] n;
    logic [52:0] keep;
    logic [53:0] sig;
    logic        up, ix, ov, un;
    int          expf;
    p = -1;
    for (int i = 0; i <= 64; i++) if (m[i]) p = i;
    if (p < 0) begin
      res = '0; flg = 3'b000; lat = 2;
      return;
    end
    if (p == 64) begin
      keep = m[64:12]; rem = int'(m[11:0]); half = 'h800; ee = e + 1; lat = 3;
    end else begin
      sh = 63 - p;
      if (sh > e - 1) sh = e - 1;
      n = m << sh;
      keep = n[63:11]; rem = int'(n[10:0]); half = 'h400; ee = e - sh; lat = 3 + sh;
    end
    up  = (rem > half) || (rem == half && keep[0]);
    ix  = (rem != 0);
    sig = {1'b0, keep} + 54'(up);
    if (sig[53]) begin
      sig = sig >> 1;
      ee  = ee + 1;
    end
    if (ee >= 2047) begin
      res = {s, 11'h7FF, 52'h0}; ov = 1'b1; ix = 1'b1; un = 1'b0;
    end else begin
      expf = sig[52] ? ee : 0;
      res  = {s, 11'(expf), sig[51:0]};
      ov   = 1'b0;
      un   = (expf == 0) && ix;
    end
    flg = {ov, un, ix};
  endfunction

  task automatic run_txn(input logic [64:0] m, input logic [10:0] e, input logic s,
                         input logic [63:0] x_res, input logic [2:0] x_flg,
                         input int x_lat, input int hold);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_mant  = m;
    bus.in_exp   = e;
    bus.in_sign  = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 64'(lat), 64'(x_lat));
    chk("result", bus.out_result, x_res);
    chk("flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}), 64'(x_flg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", bus.out_result, x_res);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_rand(input logic [64:0] m, input logic [10:0] e, input logic s, input int hold);
    logic [63:0] res;
    logic [2:0]  flg;
    int          lat;
    ref_model(m, int'(e), s, res, flg, lat);
    run_txn(m, e, s, res, flg, lat, hold);
  endtask

  initial begin
    logic [64:0] m;
    logic [63:0] r64;
    logic [10:0] e;
    int          cnt;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    chk("rst_flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    run_txn(65'h1_0000_0000_0000_0000, 11'd1023, 1'b0, 64'h4000000000000000, 3'b000, 3, 5);
    run_txn(65'd1 << 61, 11'd1023, 1'b0, 64'h3FD0000000000000, 3'b000, 5, 0);
    run_txn((65'd1 << 63) | (65'd1 << 11) | (65'd1 << 10), 11'd1023, 1'b0,
            64'h3FF0000000000002, 3'b001, 3, 0);
    run_txn((65'd1 << 63) | (65'd1 << 10), 11'd1023, 1'b0, 64'h3FF0000000000000, 3'b001, 3, 0);
    run_txn(65'h1_0000_0000_0000_0000, 11'd2046, 1'b0, 64'h7FF0000000000000, 3'b101, 3, 0);
    run_txn(65'd1 << 62, 11'd1, 1'b0, 64'h0008000000000000, 3'b000, 3, 0);
    run_txn(65'd0, 11'd1023, 1'b1, 64'h0, 3'b000, 2, 1);

    // Reset while normalising: the transaction must vanish.
    @(negedge clk);
    bus.in_mant  = 65'd1 << 40;
    bus.in_exp   = 11'd1023;
    bus.in_sign  = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    cnt = 0;
    repeat (70) begin
      @(posedge clk);
      #1 if (bus.out_valid) cnt++;
    end
    chk("mid_rst_no_output", 64'(cnt), 64'd0);
    run_txn(65'h1_0000_0000_0000_0000, 11'd1023, 1'b1, 64'hC000000000000000, 3'b000, 3, 0);

    for (int it = 0; it < 300; it++) begin
      r64 = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       m = {1'b1, r64};
        1:       m = '0;
        2:       m = {1'b0, 1'b1, r64[62:11], 11'h400};
        3:       m = {1'b0, 53'h1F_FFFF_FFFF_FFFF, r64[10:0]};
        default: m = {1'b0, 1'b1, r64[62:0]} >> $urandom_range(0, 64);
      endcase
      case ($urandom_range(0, 3))
        0:       e = 11'($urandom_range(1, 64));
        1:       e = 11'($urandom_range(2030, 2046));
        default: e = 11'($urandom_range(1, 2046));
      endcase
      run_rand(m, e, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
